// File: rtl/mem_arb_pkg.sv
// Shared types and size helpers for the two-port line-fill/writeback memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    localparam int DEFAULT_LINE_SIZE = 64;

    function automatic int line_words(input int lineSize);
        return lineSize / 4;
    endfunction

    // A single-word line still needs a 1-bit beat counter to stay legal.
    function automatic int beat_width(input int lineSize);
        return (lineSize / 4 > 1) ? $clog2(lineSize / 4) : 1;
    endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker: on a tie the side that was not served last wins.
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic       i_req_i,
    input  logic       d_req_i,
    input  owner_e     last_owner_i,
    output logic [1:0] gnt_o
);

    // gnt_o[0] grants the instruction side, gnt_o[1] the data side.
    always_comb begin
        gnt_o = 2'b00;
        if (i_req_i && d_req_i) begin
            if (last_owner_i == OWN_D) begin
                gnt_o = 2'b01;
            end else begin
                gnt_o = 2'b10;
            end
        end else if (i_req_i) begin
            gnt_o = 2'b01;
        end else if (d_req_i) begin
            gnt_o = 2'b10;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction and data line bursts onto one word-wide memory port,
// one owner per burst, with a one-cycle DONE gap between bursts.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LINE_SIZE = DEFAULT_LINE_SIZE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req_i,
    input  logic [31:0] i_addr_i,
    output logic        i_gnt_o,
    output logic        i_rvalid_o,
    output logic        i_done_o,
    output logic [31:0] i_rdata_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    output logic        d_gnt_o,
    output logic        d_rvalid_o,
    output logic        d_wnext_o,
    output logic        d_done_o,
    output logic [31:0] d_rdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int                LINE_WORDS = line_words(LINE_SIZE);
    localparam int                BEAT_W     = beat_width(LINE_SIZE);
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(LINE_WORDS - 1);
    localparam logic [31:0]       LINE_MASK  = ~(32'(LINE_SIZE) - 32'd1);

    state_e             state_q, state_d;
    owner_e             owner_q, owner_d;
    owner_e             lastOwner_q, lastOwner_d;
    logic               we_q, we_d;
    logic [31:0]        base_q, base_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [1:0]         gnt;
    logic               inIdle, inXfer, readBeat, writeBeat;

    mem_arb_rr u_rr (
        .i_req_i      (i_req_i),
        .d_req_i      (d_req_i),
        .last_owner_i (lastOwner_q),
        .gnt_o        (gnt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_I;
            lastOwner_q <= OWN_I;
            we_q        <= 1'b0;
            base_q      <= 32'd0;
            beat_q      <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            lastOwner_q <= lastOwner_d;
            we_q        <= we_d;
            base_q      <= base_d;
            beat_q      <= beat_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        lastOwner_d = lastOwner_q;
        we_d        = we_q;
        base_d      = base_q;
        beat_d      = beat_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt != 2'b00) begin
                    owner_d = gnt[1] ? OWN_D : OWN_I;
                    base_d  = (gnt[1] ? d_addr_i : i_addr_i) & LINE_MASK;
                    we_d    = gnt[1] & d_we_i;
                    beat_d  = '0;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (mem_ack_i) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = ST_DONE;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                lastOwner_d = owner_q;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Grants are masked while reset is held so nothing pulses during reset.
    always_comb begin
        inIdle    = (state_q == ST_IDLE);
        inXfer    = (state_q == ST_XFER);
        readBeat  = inXfer && !we_q;
        writeBeat = inXfer && we_q;

        i_gnt_o     = rst_n && inIdle && gnt[0];
        d_gnt_o     = rst_n && inIdle && gnt[1];
        mem_req_o   = inXfer;
        mem_we_o    = writeBeat;
        mem_addr_o  = inXfer ? (base_q + (32'(beat_q) << 2)) : 32'd0;
        mem_wdata_o = writeBeat ? d_wdata_i : 32'd0;

        i_rvalid_o  = readBeat && (owner_q == OWN_I) && mem_ack_i;
        d_rvalid_o  = readBeat && (owner_q == OWN_D) && mem_ack_i;
        i_rdata_o   = (readBeat && (owner_q == OWN_I)) ? mem_rdata_i : 32'd0;
        d_rdata_o   = (readBeat && (owner_q == OWN_D)) ? mem_rdata_i : 32'd0;
        d_wnext_o   = writeBeat && mem_ack_i;

        i_done_o    = (state_q == ST_DONE) && (owner_q == OWN_I);
        d_done_o    = (state_q == ST_DONE) && (owner_q == OWN_D);
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with the default 64-byte line (16 beats).
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        i_req_i;
    logic [31:0] i_addr_i;
    logic        i_gnt_o, i_rvalid_o, i_done_o;
    logic [31:0] i_rdata_o;
    logic        d_req_i, d_we_i;
    logic [31:0] d_addr_i, d_wdata_i;
    logic        d_gnt_o, d_rvalid_o, d_wnext_o, d_done_o;
    logic [31:0] d_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    int compared   = 0;
    int mismatched = 0;

    mem_arbiter #(.LINE_SIZE(64)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_req_i     (i_req_i),
        .i_addr_i    (i_addr_i),
        .i_gnt_o     (i_gnt_o),
        .i_rvalid_o  (i_rvalid_o),
        .i_done_o    (i_done_o),
        .i_rdata_o   (i_rdata_o),
        .d_req_i     (d_req_i),
        .d_we_i      (d_we_i),
        .d_addr_i    (d_addr_i),
        .d_wdata_i   (d_wdata_i),
        .d_gnt_o     (d_gnt_o),
        .d_rvalid_o  (d_rvalid_o),
        .d_wnext_o   (d_wnext_o),
        .d_done_o    (d_done_o),
        .d_rdata_o   (d_rdata_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        i_req_i     = 1'b0;
        i_addr_i    = 32'd0;
        d_req_i     = 1'b0;
        d_we_i      = 1'b0;
        d_addr_i    = 32'd0;
        d_wdata_i   = 32'd0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'd0;
    endtask

    task automatic doReset();
        idleInputs();
        rst_n = 1'b0;
        nextCycle();
        nextCycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        i_req_i   = 1'b1;
        d_req_i   = 1'b1;
        i_addr_i  = 32'h0000_1234;
        mem_ack_i = 1'b1;
        nextCycle();
        nextCycle();
        #1;
        compared++; if ({i_gnt_o, d_gnt_o, mem_req_o, mem_we_o, i_rvalid_o, d_rvalid_o, d_wnext_o, i_done_o, d_done_o} !== 9'b0) begin mismatched++; $display("[TB] FAIL reset_strobes: got %b expected %b", {i_gnt_o, d_gnt_o, mem_req_o, mem_we_o, i_rvalid_o, d_rvalid_o, d_wnext_o, i_done_o, d_done_o}, 9'b0); end
        compared++; if (mem_addr_o !== 32'd0) begin mismatched++; $display("[TB] FAIL reset_addr: got %h expected %h", mem_addr_o, 32'd0); end
        compared++; if ({i_rdata_o, d_rdata_o, mem_wdata_o} !== 96'd0) begin mismatched++; $display("[TB] FAIL reset_data: got %h expected 0", {i_rdata_o, d_rdata_o, mem_wdata_o}); end
        idleInputs();
        rst_n = 1'b1;
        nextCycle();
    endtask

    task automatic test_ifetch();
        doReset();
        i_req_i  = 1'b1;
        i_addr_i = 32'h0000_1234;
        #1;
        compared++; if ({i_gnt_o, d_gnt_o, mem_req_o} !== 3'b100) begin mismatched++; $display("[TB] FAIL ifetch_grant: got %b expected %b", {i_gnt_o, d_gnt_o, mem_req_o}, 3'b100); end
        nextCycle();
        i_req_i = 1'b0;
        for (int b = 0; b < 16; b++) begin
            mem_ack_i   = 1'b1;
            mem_rdata_i = 32'hC0DE_0000 + 32'(b);
            #1;
            compared++; if (mem_addr_o !== 32'h0000_1200 + 32'(4 * b)) begin mismatched++; $display("[TB] FAIL ifetch_addr beat %0d: got %h expected %h", b, mem_addr_o, 32'h0000_1200 + 32'(4 * b)); end
            compared++; if ({mem_req_o, mem_we_o, i_rvalid_o, d_rvalid_o, i_done_o} !== 5'b10100) begin mismatched++; $display("[TB] FAIL ifetch_strobes beat %0d: got %b expected %b", b, {mem_req_o, mem_we_o, i_rvalid_o, d_rvalid_o, i_done_o}, 5'b10100); end
            compared++; if (i_rdata_o !== 32'hC0DE_0000 + 32'(b)) begin mismatched++; $display("[TB] FAIL ifetch_rdata beat %0d: got %h expected %h", b, i_rdata_o, 32'hC0DE_0000 + 32'(b)); end
            nextCycle();
        end
        mem_ack_i = 1'b0;
        #1;
        compared++; if ({i_done_o, d_done_o, mem_req_o, i_rvalid_o} !== 4'b1000) begin mismatched++; $display("[TB] FAIL ifetch_done: got %b expected %b", {i_done_o, d_done_o, mem_req_o, i_rvalid_o}, 4'b1000); end
        nextCycle();
        #1;
        compared++; if ({i_done_o, mem_req_o} !== 2'b00) begin mismatched++; $display("[TB] FAIL ifetch_idle: got %b expected %b", {i_done_o, mem_req_o}, 2'b00); end
    endtask

    // Covers the first tie going to data and the waiting instruction request.
    task automatic test_tie_and_wait();
        doReset();
        i_req_i  = 1'b1;
        i_addr_i = 32'h0000_3000;
        d_req_i  = 1'b1;
        d_we_i   = 1'b0;
        d_addr_i = 32'h0000_4010;
        #1;
        compared++; if ({i_gnt_o, d_gnt_o} !== 2'b01) begin mismatched++; $display("[TB] FAIL tie1_grant: got %b expected %b", {i_gnt_o, d_gnt_o}, 2'b01); end
        nextCycle();
        d_req_i = 1'b0;
        for (int b = 0; b < 16; b++) begin
            mem_ack_i   = 1'b1;
            mem_rdata_i = 32'hD000_0000 + 32'(b);
            #1;
            compared++; if ({d_rvalid_o, i_rvalid_o, i_gnt_o, d_gnt_o} !== 4'b1000) begin mismatched++; $display("[TB] FAIL dread_strobes beat %0d: got %b expected %b", b, {d_rvalid_o, i_rvalid_o, i_gnt_o, d_gnt_o}, 4'b1000); end
            compared++; if (mem_addr_o !== 32'h0000_4000 + 32'(4 * b)) begin mismatched++; $display("[TB] FAIL dread_addr beat %0d: got %h expected %h", b, mem_addr_o, 32'h0000_4000 + 32'(4 * b)); end
            compared++; if (d_rdata_o !== 32'hD000_0000 + 32'(b)) begin mismatched++; $display("[TB] FAIL dread_rdata beat %0d: got %h expected %h", b, d_rdata_o, 32'hD000_0000 + 32'(b)); end
            nextCycle();
        end
        mem_ack_i = 1'b0;
        #1;
        compared++; if ({d_done_o, i_done_o, i_gnt_o} !== 3'b100) begin mismatched++; $display("[TB] FAIL dread_done: got %b expected %b", {d_done_o, i_done_o, i_gnt_o}, 3'b100); end
        nextCycle();
        d_req_i = 1'b1;
        #1;
        compared++; if ({i_gnt_o, d_gnt_o} !== 2'b10) begin mismatched++; $display("[TB] FAIL tie2_grant: got %b expected %b", {i_gnt_o, d_gnt_o}, 2'b10); end
        nextCycle();
        i_req_i   = 1'b0;
        d_req_i   = 1'b0;
        mem_ack_i = 1'b1;
        #1;
        compared++; if (mem_addr_o !== 32'h0000_3000) begin mismatched++; $display("[TB] FAIL tie2_addr: got %h expected %h", mem_addr_o, 32'h0000_3000); end
        for (int b = 0; b < 16; b++) begin
            mem_ack_i = 1'b1;
            nextCycle();
        end
        mem_ack_i = 1'b0;
        #1;
        compared++; if ({i_done_o, d_done_o} !== 2'b10) begin mismatched++; $display("[TB] FAIL tie2_done: got %b expected %b", {i_done_o, d_done_o}, 2'b10); end
        nextCycle();
    endtask

    task automatic test_writeback();
        int wnextCount;
        wnextCount = 0;
        d_req_i  = 1'b1;
        d_we_i   = 1'b1;
        d_addr_i = 32'h0000_8040;
        #1;
        compared++; if ({i_gnt_o, d_gnt_o} !== 2'b01) begin mismatched++; $display("[TB] FAIL wb_grant: got %b expected %b", {i_gnt_o, d_gnt_o}, 2'b01); end
        nextCycle();
        d_req_i = 1'b0;
        for (int b = 0; b < 16; b++) begin
            d_wdata_i = 32'h0000_00A0 + 32'(b);
            mem_ack_i = 1'b0;
            #1;
            compared++; if ({mem_req_o, mem_we_o, d_wnext_o} !== 3'b110) begin mismatched++; $display("[TB] FAIL wb_wait beat %0d: got %b expected %b", b, {mem_req_o, mem_we_o, d_wnext_o}, 3'b110); end
            compared++; if (mem_addr_o !== 32'h0000_8040 + 32'(4 * b)) begin mismatched++; $display("[TB] FAIL wb_addr beat %0d: got %h expected %h", b, mem_addr_o, 32'h0000_8040 + 32'(4 * b)); end
            nextCycle();
            mem_ack_i = 1'b1;
            #1;
            compared++; if ({d_wnext_o, d_rvalid_o} !== 2'b10) begin mismatched++; $display("[TB] FAIL wb_wnext beat %0d: got %b expected %b", b, {d_wnext_o, d_rvalid_o}, 2'b10); end
            compared++; if (mem_wdata_o !== 32'h0000_00A0 + 32'(b)) begin mismatched++; $display("[TB] FAIL wb_wdata beat %0d: got %h expected %h", b, mem_wdata_o, 32'h0000_00A0 + 32'(b)); end
            if (d_wnext_o === 1'b1) wnextCount++;
            nextCycle();
        end
        mem_ack_i = 1'b0;
        #1;
        compared++; if ({d_done_o, d_wnext_o, mem_req_o} !== 3'b100) begin mismatched++; $display("[TB] FAIL wb_done: got %b expected %b", {d_done_o, d_wnext_o, mem_req_o}, 3'b100); end
        compared++; if (wnextCount !== 16) begin mismatched++; $display("[TB] FAIL wb_wnext_count: got %0d expected %0d", wnextCount, 16); end
        d_we_i = 1'b0;
        nextCycle();
    endtask

    task automatic test_reset_midburst();
        i_req_i  = 1'b1;
        i_addr_i = 32'h0000_5678;
        nextCycle();
        i_req_i = 1'b0;
        for (int b = 0; b < 7; b++) begin
            mem_ack_i = 1'b1;
            nextCycle();
        end
        rst_n = 1'b0;
        #1;
        compared++; if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h0000_565C}) begin mismatched++; $display("[TB] FAIL abort_beat7: got %b/%h expected 1/0000565c", mem_req_o, mem_addr_o); end
        nextCycle();
        mem_ack_i = 1'b0;
        #1;
        compared++; if ({mem_req_o, i_done_o, i_rvalid_o} !== 3'b000) begin mismatched++; $display("[TB] FAIL abort_stop: got %b expected %b", {mem_req_o, i_done_o, i_rvalid_o}, 3'b000); end
        nextCycle();
        #1;
        compared++; if ({i_done_o, d_done_o} !== 2'b00) begin mismatched++; $display("[TB] FAIL abort_nodone: got %b expected %b", {i_done_o, d_done_o}, 2'b00); end
        rst_n    = 1'b1;
        i_req_i  = 1'b1;
        i_addr_i = 32'h0000_5678;
        #1;
        compared++; if (i_gnt_o !== 1'b1) begin mismatched++; $display("[TB] FAIL abort_regrant: got %b expected %b", i_gnt_o, 1'b1); end
        nextCycle();
        i_req_i   = 1'b0;
        mem_ack_i = 1'b1;
        #1;
        compared++; if (mem_addr_o !== 32'h0000_5640) begin mismatched++; $display("[TB] FAIL abort_restart_addr: got %h expected %h", mem_addr_o, 32'h0000_5640); end
        for (int b = 0; b < 16; b++) begin
            mem_ack_i = 1'b1;
            nextCycle();
        end
        mem_ack_i = 1'b0;
        #1;
        compared++; if (i_done_o !== 1'b1) begin mismatched++; $display("[TB] FAIL abort_restart_done: got %b expected %b", i_done_o, 1'b1); end
        nextCycle();
    endtask

    task automatic test_spurious_ack();
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h0000_DEAD;
        for (int c = 0; c < 3; c++) begin
            #1;
            compared++; if ({i_rvalid_o, d_rvalid_o, d_wnext_o, i_done_o, d_done_o, mem_req_o} !== 6'b0) begin mismatched++; $display("[TB] FAIL spurious cycle %0d: got %b expected %b", c, {i_rvalid_o, d_rvalid_o, d_wnext_o, i_done_o, d_done_o, mem_req_o}, 6'b0); end
            nextCycle();
        end
        mem_ack_i = 1'b0;
        d_req_i   = 1'b1;
        d_we_i    = 1'b0;
        d_addr_i  = 32'h0000_9000;
        #1;
        compared++; if (d_gnt_o !== 1'b1) begin mismatched++; $display("[TB] FAIL spurious_grant: got %b expected %b", d_gnt_o, 1'b1); end
        nextCycle();
        d_req_i = 1'b0;
        #1;
        compared++; if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h0000_9000}) begin mismatched++; $display("[TB] FAIL spurious_beat0: got %b/%h expected 1/00009000", mem_req_o, mem_addr_o); end
        for (int b = 0; b < 16; b++) begin
            mem_ack_i = 1'b1;
            nextCycle();
        end
        mem_ack_i = 1'b0;
        #1;
        compared++; if (d_done_o !== 1'b1) begin mismatched++; $display("[TB] FAIL spurious_done: got %b expected %b", d_done_o, 1'b1); end
        nextCycle();
    endtask

    initial begin
        idleInputs();
        rst_n = 1'b0;
        test_reset();
        test_ifetch();
        test_tie_and_wait();
        test_writeback();
        test_reset_midburst();
        test_spurious_ack();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
